// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one SRAM-like bus port between instruction fetch and data access.
// Data requests win over fetch because they belong to the older instruction.
// Only one transaction is outstanding at a time. Read data is held in output
// registers until the pipeline advances, which happens on any cycle where
// cpu_stall is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   inst_*                   fetch request / address / registered instruction
//   data_*                   load/store request, attributes, registered load data
//   stallreq_from_if/mem     combinational "not yet complete" flags
//   cpu_stall, flush_except  pipeline stall and exception flush
//   bus_*                    memory bus request side, plus addr_ok/data_ok/rdata
//
// state | meaning
// IDLE  | no transaction; pick a winner and latch its fields
// ADDR  | bus_req high with latched fields; wait for bus_addr_ok
// DATA  | address accepted; wait for bus_data_ok
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                stallreq_from_if,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                stallreq_from_mem,
  input  logic                cpu_stall,
  input  logic                flush_except,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t state_q, state_d;
  logic   own_q;
  logic   inst_done, data_done, discard_q;
  logic   inst_pend, data_pend;
  logic   grant_d, grant_i, xfer_done;
  logic   inst_cap, data_cap;

  assign inst_pend         = inst_req & ~inst_done;
  assign data_pend         = data_req & ~data_done;
  assign stallreq_from_if  = inst_pend;
  assign stallreq_from_mem = data_pend;

  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    xfer_done = 1'b0;
    bus_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_pend) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end else if (inst_pend && !flush_except) begin
          grant_i = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        bus_req = 1'b1;
        // data_ok seen here is not for us; only addr_ok advances.
        if (bus_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (bus_data_ok) begin
          xfer_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush landing on the completion edge discards the fetch as well.
  assign data_cap = xfer_done & (own_q == OWN_D);
  assign inst_cap = xfer_done & (own_q == OWN_I) & ~(discard_q | flush_except);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      own_q     <= OWN_I;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        own_q     <= OWN_D;
        bus_wr    <= data_wr;
        bus_size  <= data_size;
        bus_addr  <= data_addr;
        bus_wstrb <= data_wstrb;
        bus_wdata <= data_wdata;
      end else if (grant_i) begin
        own_q     <= OWN_I;
        bus_wr    <= 1'b0;
        bus_size  <= 2'd2;
        bus_addr  <= inst_addr;
        bus_wstrb <= '0;
        bus_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      if (data_cap) data_rdata <= bus_rdata;
      if (inst_cap) inst_rdata <= bus_rdata;

      // Set wins over clear: a result landing on an advancing edge is kept.
      if (data_cap)        data_done <= 1'b1;
      else if (!cpu_stall) data_done <= 1'b0;

      if (inst_cap)                         inst_done <= 1'b1;
      else if (flush_except || !cpu_stall)  inst_done <= 1'b0;

      // A flushed fetch still drains on the bus; its data is dropped on arrival.
      if (xfer_done && own_q == OWN_I)
        discard_q <= 1'b0;
      else if (flush_except && own_q == OWN_I && state_q != IDLE)
        discard_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        stallreq_from_if;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stallreq_from_mem;
  logic        cpu_stall;
  logic        flush_except;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  logic force_stall;
  assign cpu_stall = stallreq_from_if | stallreq_from_mem | force_stall;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .stallreq_from_if(stallreq_from_if),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .stallreq_from_mem(stallreq_from_mem),
    .cpu_stall(cpu_stall), .flush_except(flush_except),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Expected bus transactions, pushed when the CPU side is driven.
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_wd;
  } btx_t;
  btx_t sb[$];

  function automatic btx_t fetch_tx(input logic [31:0] a);
    btx_t t;
    t.wr = 1'b0; t.size = 2'd2; t.addr = a; t.wstrb = 4'h0; t.wdata = 32'h0; t.chk_wd = 1'b0;
    return t;
  endfunction

  function automatic btx_t data_tx(input logic w, input logic [1:0] s, input logic [31:0] a,
                                   input logic [3:0] st, input logic [31:0] d);
    btx_t t;
    t.wr = w; t.size = s; t.addr = a; t.wstrb = st; t.wdata = d; t.chk_wd = 1'b1;
    return t;
  endfunction

  // Bus slave model knobs, written by the main sequence.
  int          cur_adly = 0, cur_ddly = 0;
  logic        cur_both = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;
  int          phase = 0;
  logic [31:0] acc_addr;

  initial begin : responder
    int cnt;
    btx_t e;
    cnt = 0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (!rst) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (bus_req) begin
          chk("bus_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb[0];
            chk("bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, e.chk_wd ? bus_wdata : 32'h0},
                              {e.wr, e.size, e.wstrb, e.addr, e.chk_wd ? e.wdata : 32'h0});
            if (cnt >= cur_adly) begin
              bus_addr_ok = 1'b1;
              acc_addr = bus_addr;
              void'(sb.pop_front());
              phase = 1; cnt = 0;
              if (cur_both) begin
                bus_data_ok = 1'b1;
                bus_rdata   = 32'hBAD0_BAD0;
              end
            end else cnt++;
          end
        end
      end else begin
        chk("bus_req_in_data", bus_req, 1'b0);
        if (cnt >= cur_ddly) begin
          bus_data_ok = 1'b1;
          bus_rdata   = ovr_en ? ovr_val : rd_fn(acc_addr);
          ovr_en = 1'b0;
          phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq, dwr;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [3:0]  dstrb;
    logic [31:0] dwdata;
    int          adly, ddly;
    logic        both;
    logic [31:0] exp_inst, exp_data;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] last_i = 32'h0, last_d = 32'h0;

  task automatic add_vec(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [1:0] ds, input logic [31:0] da, input logic [3:0] st,
                         input logic [31:0] wd, input int ad, input int dd, input logic bo);
    vec_t v;
    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw; v.dsize = ds; v.daddr = da;
    v.dstrb = st; v.dwdata = wd; v.adly = ad; v.ddly = dd; v.both = bo;
    if (ir) last_i = rd_fn(ia);
    if (dr) last_d = rd_fn(da);
    v.exp_inst = last_i; v.exp_data = last_d;
    vecs.push_back(v);
  endtask

  task automatic wait_clear(input string name, output int c_mem, output int c_if);
    bit ok;
    ok = 0; c_mem = -1; c_if = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c_mem < 0 && !stallreq_from_mem) c_mem = c;
      if (c_if < 0 && !stallreq_from_if) c_if = c;
      if (!stallreq_from_mem && !stallreq_from_if) begin ok = 1; break; end
    end
    chk({name, "_complete"}, ok, 1'b1);
  endtask

  task automatic wait_addr_acc(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (phase == 1) begin ok = 1; break; end
    end
    chk({name, "_addr_acc"}, ok, 1'b1);
  endtask

  task automatic wait_data_ok(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_data_ok && phase == 0) begin ok = 1; break; end
    end
    chk({name, "_data_ok"}, ok, 1'b1);
  endtask

  initial begin : main
    int cm, ci;
    rst = 1'b0; force_stall = 1'b0; flush_except = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_fields", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, '0);
    chk("rst_rdata", {inst_rdata, data_rdata}, '0);
    chk("rst_stalls", {stallreq_from_if, stallreq_from_mem}, 2'b00);

    add_vec(1, 32'hBFC0_0000, 0, 0, 2'd0, 32'h0,         4'h0, 32'h0,         0, 0, 0);
    add_vec(1, 32'hBFC0_0004, 1, 0, 2'd2, 32'h8000_0010, 4'h0, 32'h0,         0, 0, 0);
    add_vec(1, 32'hBFC0_0008, 1, 1, 2'd2, 32'h8000_1000, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
    add_vec(1, 32'hBFC0_000C, 0, 0, 2'd0, 32'h0,         4'h0, 32'h0,         2, 3, 0);
    add_vec(0, 32'hBFC0_000C, 1, 1, 2'd0, 32'h8000_0003, 4'h8, 32'hAB00_0000, 1, 0, 0);
    add_vec(1, 32'hBFC0_0010, 1, 0, 2'd2, 32'h8000_0020, 4'h0, 32'h0,         0, 0, 1);
    add_vec(1, 32'hBFC0_0014, 1, 0, 2'd1, 32'h8000_0022, 4'h0, 32'h0,         1, 1, 1);

    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      cur_adly = vecs[k].adly; cur_ddly = vecs[k].ddly; cur_both = vecs[k].both;
      inst_req = vecs[k].ireq; inst_addr = vecs[k].iaddr;
      data_req = vecs[k].dreq; data_wr = vecs[k].dwr; data_size = vecs[k].dsize;
      data_addr = vecs[k].daddr; data_wstrb = vecs[k].dstrb; data_wdata = vecs[k].dwdata;
      if (vecs[k].dreq)
        sb.push_back(data_tx(vecs[k].dwr, vecs[k].dsize, vecs[k].daddr, vecs[k].dstrb, vecs[k].dwdata));
      if (vecs[k].ireq) sb.push_back(fetch_tx(vecs[k].iaddr));
      wait_clear($sformatf("vec%0d", k), cm, ci);
      chk($sformatf("vec%0d_inst_rdata", k), inst_rdata, vecs[k].exp_inst);
      chk($sformatf("vec%0d_data_rdata", k), data_rdata, vecs[k].exp_data);
      if (vecs[k].ireq && vecs[k].dreq)
        chk($sformatf("vec%0d_mem_before_if", k), cm < ci, 1'b1);
    end
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0; cur_adly = 0; cur_ddly = 0; cur_both = 1'b0;

    // Fetch latency: request at cycle 0, bus_req only at cycle 1, result at cycle 3.
    ovr_en = 1'b1; ovr_val = 32'h2402_0001;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0020; sb.push_back(fetch_tx(32'hBFC0_0020));
    @(negedge clk); chk("lat_c0_bus_req", bus_req, 1'b0);
    @(negedge clk); chk("lat_c1_bus_req", bus_req, 1'b1);
    @(negedge clk); chk("lat_c2_bus_req", bus_req, 1'b0);
    chk("lat_c2_stall_if", stallreq_from_if, 1'b1);
    @(negedge clk); chk("lat_c3_stall_if", stallreq_from_if, 1'b0);
    chk("lat_c3_inst_rdata", inst_rdata, 32'h2402_0001);

    // Result held across a 4-cycle pipeline stall, no refetch.
    @(posedge clk); #1;
    force_stall = 1'b1; inst_addr = 32'hBFC0_0040; sb.push_back(fetch_tx(32'hBFC0_0040));
    wait_clear("stall", cm, ci);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", c), {bus_req, stallreq_from_if, inst_rdata},
          {1'b0, 1'b0, rd_fn(32'hBFC0_0040)});
    end
    @(posedge clk); #1; force_stall = 1'b0;
    @(negedge clk); chk("stall_release_done_held", stallreq_from_if, 1'b0);
    @(posedge clk); #1; inst_addr = 32'hBFC0_0044; sb.push_back(fetch_tx(32'hBFC0_0044));
    @(negedge clk); chk("stall_done_cleared", stallreq_from_if, 1'b1);
    wait_clear("stall_next", cm, ci);
    chk("stall_next_rdata", inst_rdata, rd_fn(32'hBFC0_0044));

    // Flush while the fetch sits in DATA; the late data must be dropped.
    ovr_en = 1'b1; ovr_val = 32'h1111_1111; cur_ddly = 3;
    @(posedge clk); #1;
    inst_addr = 32'hBFC0_0100; sb.push_back(fetch_tx(32'hBFC0_0100));
    wait_addr_acc("flush");
    @(posedge clk); #1;
    flush_except = 1'b1; inst_addr = 32'hBFC0_0380; sb.push_back(fetch_tx(32'hBFC0_0380));
    @(posedge clk); #1; flush_except = 1'b0;
    wait_data_ok("flush");
    cur_ddly = 0;
    @(negedge clk);
    chk("flush_rdata_kept", inst_rdata, rd_fn(32'hBFC0_0044));
    chk("flush_stall_if", stallreq_from_if, 1'b1);
    wait_clear("flush_refetch", cm, ci);
    chk("flush_refetch_rdata", inst_rdata, rd_fn(32'hBFC0_0380));

    // Flush on the same edge as data_ok.
    ovr_en = 1'b1; ovr_val = 32'h2222_2222;
    @(posedge clk); #1;
    inst_addr = 32'hBFC0_0200; sb.push_back(fetch_tx(32'hBFC0_0200));
    wait_addr_acc("flush_same");
    @(posedge clk); #1;
    flush_except = 1'b1; inst_addr = 32'hBFC0_0390; sb.push_back(fetch_tx(32'hBFC0_0390));
    @(posedge clk); #1; flush_except = 1'b0;
    @(negedge clk);
    chk("flush_same_rdata_kept", inst_rdata, rd_fn(32'hBFC0_0380));
    chk("flush_same_stall_if", stallreq_from_if, 1'b1);
    wait_clear("flush_same_refetch", cm, ci);
    chk("flush_same_refetch_rdata", inst_rdata, rd_fn(32'hBFC0_0390));

    // Slow addr_ok; bus fields must not follow changing CPU inputs.
    @(posedge clk); #1;
    inst_req = 1'b0; cur_adly = 5;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_2000;
    data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
    sb.push_back(data_tx(1'b1, 2'd2, 32'h8000_2000, 4'hF, 32'hCAFE_F00D));
    repeat (3) @(negedge clk);
    data_addr = 32'h8000_2FFC; data_wdata = 32'h0;
    wait_clear("slow_addr", cm, ci);
    chk("slow_addr_data_rdata", data_rdata, rd_fn(32'h8000_2000));
    @(posedge clk); #1; data_req = 1'b0; cur_adly = 0;

    // Asynchronous reset in DATA, then the still-pending fetch restarts.
    cur_ddly = 4;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0500; sb.push_back(fetch_tx(32'hBFC0_0500));
    wait_addr_acc("rst_mid");
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_mid_bus", {bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, '0);
    chk("rst_mid_rdata", {inst_rdata, data_rdata}, '0);
    chk("rst_mid_stalls", {stallreq_from_if, stallreq_from_mem}, 2'b10);
    @(posedge clk);
    @(negedge clk);
    sb.push_back(fetch_tx(32'hBFC0_0500));
    cur_ddly = 0; rst = 1'b1;
    wait_clear("rst_restart", cm, ci);
    chk("rst_restart_rdata", inst_rdata, rd_fn(32'hBFC0_0500));
    chk("sb_empty", sb.size(), 0);

    @(posedge clk); #1; inst_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares one SRAM-like memory port between the pipeline's instruction-fetch side (F stage) and data-access side (M stage).
- Produces the `stallreq_from_if` / `stallreq_from_mem` signals consumed by the hazard unit.
- Holds each completed transaction's read data until the pipeline advances.
- Drains bus transactions in flight across an exception flush without corrupting the refetched stream.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `inst_req` in 1: fetch request for `inst_addr`; held high by the CPU until it advances.
- `inst_addr` in 32: fetch address (`pcF`).
- `inst_rdata` out 32: fetched instruction (`instrF`), registered.
- `stallreq_from_if` out 1: fetch not yet complete.
- `data_req` in 1: load/store request; OR of `readEnM`/`writeEnM`.
- `data_wr` in 1: 1 = store.
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` in 32: `aluoutM`.
- `data_wstrb` in 4: `writeEnM`.
- `data_wdata` in 32: `writedata_decodedM`.
- `data_rdata` out 32: load data, registered.
- `stallreq_from_mem` out 1: data access not yet complete.
- `cpu_stall` in 1: any pipeline stall (stallF | stallM from the hazard unit).
- `flush_except` in 1: exception/eret flush.
- `bus_req` out 1: bus request.
- `bus_wr` out 1: bus write.
- `bus_size` out 2: bus access size.
- `bus_addr` out 32: bus address.
- `bus_wstrb` out 4: bus byte strobes.
- `bus_wdata` out 32: bus write data.
- `bus_addr_ok` in 1: address accepted by the bus.
- `bus_data_ok` in 1: transaction finished; read data valid.
- `bus_rdata` in 32: bus read data.

## Operation
- FSM states: IDLE, ADDR, DATA. Owner register `own`: I = fetch, D = data.
- Pending conditions:
  - `inst_pend = inst_req & ~inst_done`
  - `data_pend = data_req & ~data_done`
- IDLE:
  - If `data_pend`: `own`=D, go to ADDR.
  - Else if `inst_pend` and not `flush_except`: `own`=I, go to ADDR.
  - Data has fixed priority because it belongs to the older instruction.
  - On the IDLE→ADDR transition, latch addr/wr/size/wstrb/wdata of the winner into bus registers. Fetch is latched as wr=0, size=2, wstrb=0.
- ADDR: `bus_req`=1 with the latched fields. On `bus_addr_ok`, go to DATA.
- DATA: `bus_req`=0. On `bus_data_ok`, go to IDLE and then:
  - `own`=D: capture `bus_rdata` into `data_rdata`, set `data_done`.
  - `own`=I and `discard`=0: capture `bus_rdata` into `inst_rdata`, set `inst_done`.
  - `own`=I and `discard`=1: clear `discard`; `inst_rdata`/`inst_done` unchanged.
- `done` flags:
  - Set as above.
  - Cleared on any cycle with `cpu_stall`=0, because the pipeline consumes the result that edge.
  - A flag set on the same edge `cpu_stall` is low is still set; set takes priority over clear.
- Flush behaviour:
  - `flush_except`=1 with `own`=I in ADDR or DATA: set `discard`; the transaction runs to completion.
  - `flush_except` also clears `inst_done`.
  - In-flight data transactions are never discarded; the faulting instruction's store was already suppressed upstream.
- Stall outputs (combinational):
  - `stallreq_from_if = inst_req & ~inst_done`
  - `stallreq_from_mem = data_req & ~data_done`
- Latched bus fields remain stable from ADDR entry until DATA exit, even if CPU inputs change.

## Timing
Reset (`rst`=0):
- state=IDLE, `own`=I.
- `inst_done`=`data_done`=`discard`=0.
- `inst_rdata`=`data_rdata`=0.
- `bus_req`=0 and all bus fields 0.
- Stall outputs follow their equations (0 while reqs are 0).
- Reset asserted mid-transaction abandons it immediately.

Latency and throughput:
- Request first seen in IDLE at cycle 0 → `bus_req` at cycle 1.
- With `addr_ok` at cycle 1 and `data_ok` at cycle 2: rdata and done valid at cycle 3, stall drops at cycle 3.
- Minimum 3 cycles per transaction; one transaction outstanding at a time.

Boundary conditions:
- `inst_pend` and `data_pend` in the same IDLE cycle → data wins; fetch starts on the following IDLE.
- `bus_addr_ok` and `bus_data_ok` both high in ADDR → only `addr_ok` is honoured; `data_ok` is ignored outside DATA.
- `flush_except` in the same cycle as `bus_data_ok` for `own`=I → data discarded.

## Test plan
1. Fetch alone, `addr_ok` at cycle 1, `data_ok` at cycle 2 with `bus_rdata`=0x24020001 → `inst_rdata`=0x24020001 and `stallreq_from_if`=0 at cycle 3; `bus_req` high only at cycle 1.
2. Simultaneous fetch and store (addr 0x80001000, wstrb 0xF, wdata 0xDEADBEEF) → bus shows the store first with wr=1, size=2; the fetch follows. `stallreq_from_mem` falls before `stallreq_from_if`.
3. Fetch completes while `cpu_stall`=1 for 4 cycles → `inst_done` held, no second fetch issued, `inst_rdata` stable; first cycle with `cpu_stall`=0 clears `done`.
4. `flush_except` pulsed while `own`=I in DATA, then `data_ok` with 0x11111111 → `inst_rdata` unchanged, `stallreq_from_if` stays 1; refetch of the new `inst_addr` (0xBFC00380) issued next.
5. Bus `addr_ok` delayed 5 cycles → `bus_addr`/`bus_wdata` constant throughout ADDR even when `data_addr` changes.
6. `rst`=0 during DATA → all outputs reach reset values asynchronously; after release, a pending request restarts from IDLE.
